selfcomp_leak_monitor: RTL

//  Consumes the two output streams of a self-composed SE pair (copy One, copy Two; both get identical stimulus).

---
 rtl/selfcomp_leak_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/selfcomp_leak_monitor.sv
`default_nettype none
// ============================================================================
// Module      : selfcomp_leak_monitor
// Description : Timing-leak monitor for a self-composed SE pair. Timestamps
//               every accepted result of copy One and copy Two, pairs them in
//               order, and flags a leak on latency divergence or imbalance.
//               Optional feature macro: RESULT_CHECK_EN (also compares the
//               paired results and raises resultLeak on mismatch).
// Revision    : 1.0 - initial release
// ============================================================================
module selfcomp_leak_monitor #(
    parameter int DATA_W    = 128,
    parameter int TS_W      = 16,
    parameter int DEPTH     = 4,
    parameter int MAX_SKEW  = 0,
    parameter int NUM_PAIRS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_out_validOne,
    input  logic [DATA_W-1:0] io_out_resultOne,
    input  logic              io_out_validTwo,
    input  logic [DATA_W-1:0] io_out_resultTwo,
    output logic              io_out_ready,
    output logic              timingLeak,
    output logic              timingLeakDone,
    output logic [TS_W-1:0]   leakTs,
    output logic [7:0]        pairCount,
    output logic              resultLeak
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [7:0]     c_PAIRS = 8'(NUM_PAIRS);
    localparam logic [TS_W-1:0] c_SKEW = TS_W'(MAX_SKEW);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LEAK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TS_W-1:0]        r_ts;
    logic                   r_timingLeak;
    logic [TS_W-1:0]        r_leakTs;
    logic [7:0]             r_pairCount;
    logic [7:0]             w_pairInc;

    // Lane 0 = copy One, lane 1 = copy Two
    logic [1:0]             w_valid;
    logic [1:0]             w_push;
    logic [1:0]             w_full;
    logic [1:0]             w_empty;
    logic [1:0][TS_W-1:0]   w_headTs;
    logic                   w_pop;
    logic [TS_W-1:0]        w_diff;
    logic [TS_W-1:0]        w_absDiff;
    logic                   w_skewLeak;
    logic                   w_imbal;
    logic                   w_tLeak;
    logic                   w_rLeak;

    assign w_valid = {io_out_validTwo, io_out_validOne};

`ifdef RESULT_CHECK_EN
    logic [1:0][DATA_W-1:0] w_res;
    logic [1:0][DATA_W-1:0] w_headRes;
    logic                   r_resultLeak;
    assign w_res = {io_out_resultTwo, io_out_resultOne};
`else
    // Results are not compared in this build; fold them into a sink
    logic w_unused;
    assign w_unused = ^{io_out_resultOne, io_out_resultTwo};
`endif

    generate
        for (genvar l = 0; l < 2; l++) begin : g_lane
            logic [TS_W-1:0] r_tsMem [DEPTH];
            logic [c_AW-1:0] r_wp;
            logic [c_AW-1:0] r_rp;
            logic [c_AW:0]   r_cnt;

            assign w_full[l]   = (r_cnt == c_FULL);
            assign w_empty[l]  = (r_cnt == '0);
            assign w_push[l]   = w_valid[l] & io_out_ready;
            assign w_headTs[l] = r_tsMem[r_rp];

            // Pointer and occupancy bookkeeping; reset discards queued entries
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push[l]) r_wp <= r_wp + 1'b1;
                    if (w_pop)     r_rp <= r_rp + 1'b1;
                    if (w_push[l] && !w_pop)
                        r_cnt <= r_cnt + 1'b1;
                    else if (!w_push[l] && w_pop)
                        r_cnt <= r_cnt - 1'b1;
                end
            end

            // Timestamp storage; validity is tracked by r_cnt so no reset
            always_ff @(posedge clock) begin
                if (w_push[l]) r_tsMem[r_wp] <= r_ts;
            end

`ifdef RESULT_CHECK_EN
            logic [DATA_W-1:0] r_resMem [DEPTH];
            assign w_headRes[l] = r_resMem[r_rp];

            // Result storage alongside the timestamp
            always_ff @(posedge clock) begin
                if (w_push[l]) r_resMem[r_wp] <= w_res[l];
            end
`endif
        end
    endgenerate

    // Heads are popped together only while monitoring is live
    assign w_pop = (r_state == S_RUN) & ~w_empty[0] & ~w_empty[1];

    // Signed modular skew so pairs straddling the ts wrap compare correctly
    assign w_diff     = w_headTs[0] - w_headTs[1];
    assign w_absDiff  = w_diff[TS_W-1] ? (~w_diff + 1'b1) : w_diff;
    assign w_skewLeak = w_pop & (w_absDiff > c_SKEW);
    assign w_imbal    = (r_state == S_RUN) &
                        ((w_full[0] & w_empty[1]) | (w_full[1] & w_empty[0]));
    assign w_tLeak    = w_skewLeak | w_imbal;

`ifdef RESULT_CHECK_EN
    assign w_rLeak = w_pop & (w_headRes[0] != w_headRes[1]);
`else
    assign w_rLeak = 1'b0;
`endif

    assign w_pairInc = (r_pairCount == 8'hFF) ? r_pairCount : r_pairCount + 8'd1;

    // Next state and shared ready; a leak outranks reaching the pair target
    always_comb begin
        w_next_state = r_state;
        io_out_ready = (r_state == S_RUN) & ~w_full[0] & ~w_full[1];
        case (r_state)
            S_RUN: begin
                if (w_tLeak || w_rLeak)
                    w_next_state = S_LEAK;
                else if (w_pop && (w_pairInc == c_PAIRS))
                    w_next_state = S_DONE;
            end
            S_LEAK:  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_RUN;
        endcase
    end

    // State, free-running timestamp, pair counter and sticky leak flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_ts         <= '0;
            r_timingLeak <= 1'b0;
            r_leakTs     <= '0;
            r_pairCount  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ts    <= r_ts + 1'b1;
            if (w_pop) r_pairCount <= w_pairInc;
            if (w_tLeak && !r_timingLeak) begin
                r_timingLeak <= 1'b1;
                r_leakTs     <= r_ts;
            end
        end
    end

`ifdef RESULT_CHECK_EN
    // Sticky result-mismatch flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        r_resultLeak <= 1'b0;
        else if (w_rLeak) r_resultLeak <= 1'b1;
    end
    assign resultLeak = r_resultLeak;
`else
    assign resultLeak = 1'b0;
`endif

    assign timingLeak     = r_timingLeak;
    assign timingLeakDone = (r_state == S_DONE);
    assign leakTs         = r_leakTs;
    assign pairCount      = r_pairCount;

endmodule
`default_nettype wire
